// File: rtl/ring_msg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// ring_msg_sequencer_pkg
//   Shared state encoding, size defaults and encoder character constants.
//   Revision: 1.0
// ============================================================================
package ring_msg_sequencer_pkg;

  localparam int RING_W_DEFAULT = 5;
  localparam int REP_W_DEFAULT  = 4;

  localparam logic [RING_W_DEFAULT-1:0] SEL_RESET = 5'b00001;

  // Characters produced by the pattern encoder for ring positions 0..4
  localparam logic [6:0] ASCII_J = 7'h4A;
  localparam logic [6:0] ASCII_A = 7'h61;
  localparam logic [6:0] ASCII_C = 7'h63;
  localparam logic [6:0] ASCII_O = 7'h6F;
  localparam logic [6:0] ASCII_B = 7'h62;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ring_msg_sequencer_ring_select.sv
`default_nettype none
// ============================================================================
// ring_msg_sequencer_ring_select
//   One-hot ring position register with load-to-bit-0 and rotate-left.
//   Revision: 1.0
// ============================================================================
module ring_msg_sequencer_ring_select #(
  parameter int RING_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_rotate,
  output logic [RING_W-1:0] o_sel
);

  localparam logic [RING_W-1:0] SEL_INIT = {{(RING_W-1){1'b0}}, 1'b1};

  logic [RING_W-1:0] sel_q;
  logic [RING_W-1:0] sel_d;

  // Load wins over rotate so a wrap always lands on bit 0
  always_comb begin
    sel_d = sel_q;
    if (i_load) begin
      sel_d = SEL_INIT;
    end else if (i_rotate) begin
      sel_d = {sel_q[RING_W-2:0], sel_q[RING_W-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_INIT;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign o_sel = sel_q;

endmodule
`default_nettype wire

// File: rtl/ring_msg_sequencer.sv
`default_nettype none
// ============================================================================
// ring_msg_sequencer
//   Start/abort controlled ring sequencer streaming encoder chars over valid/ready.
//   Revision: 1.0
// ============================================================================
module ring_msg_sequencer
  import ring_msg_sequencer_pkg::*;
#(
  parameter int RING_W = RING_W_DEFAULT,
  parameter int REP_W  = REP_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        len,
  input  logic [REP_W-1:0]  reps,
  output logic [RING_W-1:0] sel_out,
  input  logic [6:0]        ascii_in,
  output logic [6:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0]        LEN_MAX = 3'(RING_W);
  localparam logic [RING_W-1:0] SEL_ONE = {{(RING_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [2:0]        len_q, len_d;
  logic [REP_W-1:0]  pass_q, pass_d;
  logic [6:0]        char_q, char_d;
  logic              valid_q, valid_d;

  logic              sel_load;
  logic              sel_rot;
  logic              handshake;
  logic              at_last;
  logic [2:0]        len_clamped;
  logic [RING_W-1:0] last_sel;

  assign len_clamped = ((len == 3'd0) || (len > LEN_MAX)) ? LEN_MAX : len;
  assign handshake   = valid_q & char_ready;
  // len_q is only consulted in PRESENT, where it is always 1..RING_W
  assign last_sel    = SEL_ONE << (len_q - 3'd1);
  assign at_last     = (sel_out == last_sel);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pass_d   = pass_q;
    char_d   = char_q;
    valid_d  = valid_q;
    sel_load = 1'b0;
    sel_rot  = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      sel_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            len_d    = len_clamped;
            pass_d   = reps;
            sel_load = 1'b1;
            state_d  = (reps == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          char_d  = ascii_in;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (handshake) begin
            valid_d = 1'b0;
            if (!at_last) begin
              sel_rot = 1'b1;
              state_d = ST_FETCH;
            end else if (pass_q > REP_W'(1)) begin
              sel_load = 1'b1;
              pass_d   = pass_q - REP_W'(1);
              state_d  = ST_FETCH;
            end else begin
              sel_load = 1'b1;
              state_d  = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      len_q   <= 3'd0;
      pass_q  <= '0;
      char_q  <= 7'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  ring_msg_sequencer_ring_select #(
    .RING_W (RING_W)
  ) u_ring_select (
    .clk      (CLK),
    .rst      (RST),
    .i_load   (sel_load),
    .i_rotate (sel_rot),
    .o_sel    (sel_out)
  );

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ring_msg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ring_msg_sequencer
//   Self-checking bench: vector table, corner-case sequences, random messages.
//   Revision: 1.0
// ============================================================================
module tb_ring_msg_sequencer;
  import ring_msg_sequencer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       abort;
  logic [2:0] len;
  logic [3:0] reps;
  logic [4:0] sel_out;
  logic [6:0] ascii_in;
  logic [6:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ring_msg_sequencer #(.RING_W(5), .REP_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .len        (len),
    .reps       (reps),
    .sel_out    (sel_out),
    .ascii_in   (ascii_in),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done)
  );

  // Pattern encoder stand-in
  always_comb begin
    case (sel_out)
      5'b00001: ascii_in = ASCII_J;
      5'b00010: ascii_in = ASCII_A;
      5'b00100: ascii_in = ASCII_C;
      5'b01000: ascii_in = ASCII_O;
      5'b10000: ascii_in = ASCII_B;
      default:  ascii_in = 7'h00;
    endcase
  end

  typedef struct {
    logic [2:0] len;
    logic [3:0] reps;
    int         exp_n;
    int         exp_cyc;
    logic [4:0] exp_max;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ring_char(input int pos);
    case (pos)
      0:       return ASCII_J;
      1:       return ASCII_A;
      2:       return ASCII_C;
      3:       return ASCII_O;
      default: return ASCII_B;
    endcase
  endfunction

  function automatic int eff_len(input logic [2:0] l);
    return ((l == 3'd0) || (l > 3'd5)) ? 5 : int'(l);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},   sel_out, 5'b00001);
    check({tag, "_char"},  char_out, 7'h00);
    check({tag, "_valid"}, char_valid, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
  endtask

  // mode 0: ready high, 1: random ready, 2: stall 4 cycles on second char
  task automatic run_msg(input logic [2:0] l, input logic [3:0] r, input int mode,
                         input bit noisy, output int nchars, output int ncyc,
                         output logic [4:0] maxsel);
    logic [6:0] exp_q[$];
    logic [6:0] prev_char;
    int         n;
    int         stall;
    bit         hold_bad;
    bit         onehot_bad;
    bit         prev_wait;
    exp_q.delete();
    n = eff_len(l);
    for (int p = 0; p < int'(r); p++)
      for (int i = 0; i < n; i++)
        exp_q.push_back(ring_char(i));
    nchars = 0; ncyc = 0; stall = 0; maxsel = 5'd0;
    hold_bad = 1'b0; onehot_bad = 1'b0; prev_wait = 1'b0; prev_char = 7'd0;

    @(negedge CLK);
    start = 1'b1; len = l; reps = r; char_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0; ncyc = 1;
    while (!done && ncyc < 2000) begin
      if ($countones(sel_out) != 1) onehot_bad = 1'b1;
      if (sel_out > maxsel) maxsel = sel_out;
      if (prev_wait && !(char_valid && char_out == prev_char)) hold_bad = 1'b1;
      case (mode)
        0: char_ready = 1'b1;
        1: char_ready = 1'($urandom_range(0, 1));
        default: begin
          char_ready = 1'b1;
          if (char_valid && nchars == 1 && stall < 4) begin
            char_ready = 1'b0;
            stall++;
          end
        end
      endcase
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        len   = 3'($urandom);
        reps  = 4'($urandom);
      end
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_char: got 0x%0h required no further char", char_out);
        end else begin
          check("char", char_out, exp_q.pop_front());
        end
        nchars++;
      end
      prev_wait = char_valid && !char_ready;
      prev_char = char_out;
      @(negedge CLK);
      ncyc++;
    end
    start = 1'b0;
    char_ready = 1'b1;
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout: no done after %0d cycles, required done", ncyc);
    end
    check("queue_drained", exp_q.size(), 0);
    check("onehot", onehot_bad, 1'b0);
    check("hold_while_stalled", hold_bad, 1'b0);
    if (mode == 2) check("stall_count", stall, 4);
    @(negedge CLK);
    check("done_single_pulse", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[9];
    int         nc;
    int         cy;
    int         dones;
    bit         found;
    logic [4:0] ms;
    logic [6:0] target;
    logic [2:0] rl;
    logic [3:0] rr;

    // Cycles counted from the edge that samples start up to the one entering DONE, inclusive
    vecs[0] = '{3'd5, 4'd1,  5,  11, 5'b10000};
    vecs[1] = '{3'd2, 4'd3,  6,  13, 5'b00010};
    vecs[2] = '{3'd3, 4'd1,  3,   7, 5'b00100};
    vecs[3] = '{3'd0, 4'd1,  5,  11, 5'b10000};
    vecs[4] = '{3'd7, 4'd1,  5,  11, 5'b10000};
    vecs[5] = '{3'd1, 4'd2,  2,   5, 5'b00001};
    vecs[6] = '{3'd4, 4'd0,  0,   1, 5'b00000};
    vecs[7] = '{3'd5, 4'd15, 75, 151, 5'b10000};
    vecs[8] = '{3'd6, 4'd2,  10,  21, 5'b10000};

    RST = 1'b1; start = 1'b0; abort = 1'b0; len = 3'd0; reps = 4'd0; char_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RST = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_msg(vecs[v].len, vecs[v].reps, 0, 1'b0, nc, cy, ms);
      check("tbl_nchars", nc, vecs[v].exp_n);
      check("tbl_cycles", cy, vecs[v].exp_cyc);
      check("tbl_max_sel", ms, vecs[v].exp_max);
    end

    run_msg(3'd3, 4'd1, 2, 1'b0, nc, cy, ms);
    check("stall_nchars", nc, 3);
    check("stall_cycles", cy, 11);

    // Abort while holding 0x63 (no handshake) and on 0x61 with a simultaneous handshake
    for (int v = 0; v < 2; v++) begin
      target = (v == 0) ? ASCII_C : ASCII_A;
      @(negedge CLK);
      start = 1'b1; len = 3'd5; reps = 4'd1; char_ready = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        if (char_valid && char_out == target) begin
          found = 1'b1;
          char_ready = (v == 1);
          abort = 1'b1;
        end else begin
          @(negedge CLK);
        end
      end
      check("abort_target_seen", found, 1'b1);
      @(negedge CLK);
      abort = 1'b0; char_ready = 1'b1;
      check("abort_busy", busy, 1'b0);
      check("abort_valid", char_valid, 1'b0);
      check("abort_sel", sel_out, 5'b00001);
      dones = int'(done);
      repeat (3) begin
        @(negedge CLK);
        if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_msg(3'd5, 4'd1, 0, 1'b0, nc, cy, ms);
      check("restart_nchars", nc, 5);
    end

    @(negedge CLK);
    start = 1'b1; abort = 1'b1; len = 3'd5; reps = 4'd1;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", busy, 1'b0);
    check("start_abort_idle_valid", char_valid, 1'b0);
    @(negedge CLK);
    check("start_abort_idle_busy2", busy, 1'b0);

    @(negedge CLK);
    start = 1'b1; len = 3'd5; reps = 4'd3; char_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      start = 1'($urandom_range(0, 1));
    end
    RST = 1'b1; start = 1'b0;
    @(negedge CLK);
    check_reset_values("mid_reset");
    RST = 1'b0;
    run_msg(3'd2, 4'd2, 0, 1'b0, nc, cy, ms);
    check("post_reset_nchars", nc, 4);
    check("post_reset_cycles", cy, 9);

    for (int t = 0; t < 20; t++) begin
      rl = 3'($urandom_range(0, 7));
      rr = 4'($urandom_range(0, 4));
      run_msg(rl, rr, 1, 1'b1, nc, cy, ms);
      check("rand_nchars", nc, eff_len(rl) * int'(rr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
